// File: rtl/lab06_stats.sv
// Frame statistics collector for the Lab06 result stream.
// Accumulates one contiguous in_valid frame, then emits sum, max and min as three registered beats.
module lab06_stats #(
    parameter int unsigned DATA_W  = 6,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned SUM_W   = DATA_W + $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_result,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_data,
    output logic              out_err
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN) + 1;
    localparam int unsigned EXT_W = SUM_W - DATA_W;

    typedef enum logic [2:0] {IDLE, ACC, OUT0, OUT1, OUT2} state_t;

    state_t                    state, state_nx;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic signed [DATA_W-1:0]  max_q, max_d, min_q, min_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      err_q, err_d;
    logic                      load;
    logic                      out_valid_d, out_err_d;
    logic [SUM_W-1:0]          out_data_d;

    logic signed [DATA_W-1:0]  sample;
    logic signed [SUM_W-1:0]   sample_ext;
    logic [SUM_W-1:0]          max_ext, min_ext;

    assign sample     = $signed(in_result);
    assign sample_ext = $signed({{EXT_W{in_result[DATA_W-1]}}, in_result});
    assign max_ext    = {{EXT_W{max_q[DATA_W-1]}}, max_q};
    assign min_ext    = {{EXT_W{min_q[DATA_W-1]}}, min_q};

    // Next-state, datapath update and registered-output preload
    always_comb begin
        state_nx    = state;
        sum_d       = sum_q;
        max_d       = max_q;
        min_d       = min_q;
        count_d     = count_q;
        err_d       = err_q;
        load        = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_err_d   = 1'b0;

        case (state)
            IDLE: if (in_valid) load = 1'b1;
            ACC: begin
                if (in_valid) begin
                    if (count_q < CNT_W'(MAX_LEN)) begin
                        sum_d   = sum_q + sample_ext;
                        if (sample > max_q) max_d = sample;
                        if (sample < min_q) min_d = sample;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_nx = OUT0;
                end
            end
            OUT0: state_nx = OUT1;
            OUT1: state_nx = OUT2;
            // Last beat cycle: a sample arriving here starts the next frame
            OUT2: begin
                state_nx = IDLE;
                if (in_valid) load = 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        if (load) begin
            state_nx = ACC;
            sum_d    = sample_ext;
            max_d    = sample;
            min_d    = sample;
            count_d  = CNT_W'(1);
            err_d    = 1'b0;
        end

        // Outputs are registered from the state being entered
        case (state_nx)
            OUT0: begin
                out_valid_d = 1'b1;
                out_data_d  = sum_d;
                out_err_d   = err_d;
            end
            OUT1: begin
                out_valid_d = 1'b1;
                out_data_d  = max_ext;
                out_err_d   = err_q;
            end
            OUT2: begin
                out_valid_d = 1'b1;
                out_data_d  = min_ext;
                out_err_d   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sum_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            sum_q     <= sum_d;
            max_q     <= max_d;
            min_q     <= min_d;
            count_q   <= count_d;
            err_q     <= err_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_err   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_lab06_stats.sv
// Directed self-checking bench for lab06_stats: frame beats, overflow error, dropped samples, reset abort.
module tb_lab06_stats;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned SUM_W  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_result;
    logic              out_valid;
    logic [SUM_W-1:0]  out_data;
    logic              out_err;

    int checks = 0;
    int errors = 0;

    lab06_stats dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_result (in_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SUM_W-1:0] obs, input int exp);
        checks++;
        assert (obs === SUM_W'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one sample, sample outputs 1ns after the capturing edge
    task automatic send(input int v);
        in_valid  = 1'b1;
        in_result = DATA_W'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the last sample edge En; checks En+1..En+4
    task automatic beats(input string tag, input int s, input int mx, input int mn, input logic e);
        in_valid = 1'b0;
        chkb({tag, "_quiet_en"}, out_valid, 1'b0);
        tick();
        chkb({tag, "_v0"}, out_valid, 1'b1);
        chk ({tag, "_sum"}, out_data, s);
        chkb({tag, "_e0"}, out_err, e);
        tick();
        chkb({tag, "_v1"}, out_valid, 1'b1);
        chk ({tag, "_max"}, out_data, mx);
        chkb({tag, "_e1"}, out_err, e);
        tick();
        chkb({tag, "_v2"}, out_valid, 1'b1);
        chk ({tag, "_min"}, out_data, mn);
        chkb({tag, "_e2"}, out_err, e);
        tick();
        chkb({tag, "_vend"}, out_valid, 1'b0);
        chk ({tag, "_dend"}, out_data, 0);
        chkb({tag, "_eend"}, out_err, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        #1;
        chkb("rst_valid", out_valid, 1'b0);
        chk ("rst_data", out_data, 0);
        chkb("rst_err", out_err, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Mixed-sign frame including both extremes
        send(5); send(-3); send(31); send(-32);
        beats("mix", 1, 31, -32, 1'b0);
        tick();

        send(-7);
        beats("single", -7, -7, -7, 1'b0);
        chk("single_hex", 9'h1F9, -7);
        tick();

        for (int i = 0; i < 8; i++) send(-32);
        beats("allneg", -256, -32, -32, 1'b0);
        for (int i = 0; i < 8; i++) send(31);
        beats("allpos", 248, 31, 31, 1'b0);

        // Overlong frame: only first 8 count, error held on all beats
        for (int i = 0; i < 10; i++) send(1);
        beats("ovf", 8, 1, 1, 1'b1);
        send(2); send(2);
        beats("after_ovf", 4, 2, 2, 1'b0);

        // Sample during OUT1 dropped; sample at En+4 starts next frame
        send(3); send(4);
        in_valid = 1'b0;
        tick();
        chkb("drop_v0", out_valid, 1'b1);
        chk ("drop_sum", out_data, 7);
        tick();
        chk ("drop_max", out_data, 4);
        in_valid  = 1'b1;
        in_result = DATA_W'(9);
        tick();
        chk ("drop_min", out_data, 3);
        chkb("drop_err", out_err, 1'b0);
        send(6);
        chkb("drop_vend", out_valid, 1'b0);
        send(-2);
        beats("en4", 4, 6, -2, 1'b0);
        tick();

        // Reset mid-frame discards everything
        send(1); send(2); send(3);
        rst = 1'b1;
        #1;
        chkb("rstf_valid", out_valid, 1'b0);
        chk ("rstf_data", out_data, 0);
        chkb("rstf_err", out_err, 1'b0);
        tick();
        tick();
        chkb("rstf_valid_hold", out_valid, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chkb("rstf_no_beats", out_valid, 1'b0);
        end
        send(4); send(-4);
        beats("post_rst", 0, 4, -4, 1'b0);

        // Reset during output beats kills the remaining beats at once
        send(10);
        in_valid = 1'b0;
        tick();
        chk("rsto_sum", out_data, 10);
        rst = 1'b1;
        #1;
        chkb("rsto_valid", out_valid, 1'b0);
        chk ("rsto_data", out_data, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chkb("rsto_no_beats", out_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
